// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM->WB pipeline register with load alignment, stall/flush
//            handling and a retired-write counter. Optional misaligned-load
//            trap enabled by defining WB_MISALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ld_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_excp,
    output logic [CNT_W-1:0]  wb_retired
);

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LB   = 3'd1;
    localparam logic [2:0] c_LD_LBU  = 3'd2;
    localparam logic [2:0] c_LD_LH   = 3'd3;
    localparam logic [2:0] c_LD_LHU  = 3'd4;
    localparam logic [2:0] c_LD_LW   = 3'd5;

    localparam logic [CNT_W-1:0]  c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_R0      = '0;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wreg;
    logic              w_excp;
    logic              w_bubble;

    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_retired;

    // Lane selection depends only on the memory's byte ordering.
    generate
        if (BIG_ENDIAN != 0) begin : g_big_endian
            always_comb begin
                w_byte = mem_rdata[31:24];
                case (mem_addr_lo)
                    2'd0:    w_byte = mem_rdata[31:24];
                    2'd1:    w_byte = mem_rdata[23:16];
                    2'd2:    w_byte = mem_rdata[15:8];
                    default: w_byte = mem_rdata[7:0];
                endcase
                w_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
            end
        end else begin : g_little_endian
            always_comb begin
                w_byte = mem_rdata[7:0];
                case (mem_addr_lo)
                    2'd0:    w_byte = mem_rdata[7:0];
                    2'd1:    w_byte = mem_rdata[15:8];
                    2'd2:    w_byte = mem_rdata[23:16];
                    default: w_byte = mem_rdata[31:24];
                endcase
                w_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
            end
        end
    endgenerate

    always_comb begin
        w_wdata = mem_wdata;
        w_wreg  = mem_wreg;
        w_excp  = 1'b0;
        case (mem_ld_type)
            c_LD_NONE: w_wdata = mem_wdata;
            c_LD_LB:   w_wdata = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LD_LBU:  w_wdata = {{(DATA_W-8){1'b0}}, w_byte};
            c_LD_LH:   w_wdata = {{(DATA_W-16){w_half[15]}}, w_half};
            c_LD_LHU:  w_wdata = {{(DATA_W-16){1'b0}}, w_half};
            c_LD_LW:   w_wdata = mem_rdata;
            // Reserved encodings behave as a non-load that never writes.
            default: begin
                w_wdata = mem_wdata;
                w_wreg  = 1'b0;
            end
        endcase
`ifdef WB_MISALIGN_CHECK_EN
        if ((((mem_ld_type == c_LD_LH) || (mem_ld_type == c_LD_LHU)) && mem_addr_lo[0]) ||
            ((mem_ld_type == c_LD_LW) && (mem_addr_lo != 2'd0))) begin
            w_wreg = 1'b0;
            w_excp = 1'b1;
        end
`endif
    end

    // A stalled MEM stage with a free WB stage must not leave a stale entry.
    assign w_bubble = flush || (stall_mem && !stall_wb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wreg    <= 1'b0;
            r_wd      <= '0;
            r_wdata   <= '0;
            r_retired <= '0;
        end else if (w_bubble) begin
            r_wreg  <= 1'b0;
            r_wd    <= '0;
            r_wdata <= '0;
        end else if (stall_wb) begin
            // The regfile already consumed the write on the first held edge.
            r_wreg <= 1'b0;
        end else begin
            r_wreg  <= w_wreg;
            r_wd    <= mem_wd;
            r_wdata <= w_wdata;
            if (w_wreg && (mem_wd != c_R0)) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

`ifdef WB_MISALIGN_CHECK_EN
    logic r_excp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_excp <= 1'b0;
        end else if (w_bubble) begin
            r_excp <= 1'b0;
        end else if (!stall_wb) begin
            r_excp <= w_excp;
        end
    end

    assign wb_excp = r_excp;
`else
    logic w_excp_unused;
    assign w_excp_unused = w_excp;
    assign wb_excp       = 1'b0;
`endif

    assign wb_wreg    = r_wreg;
    assign wb_wd      = r_wd;
    assign wb_wdata   = r_wdata;
    assign wb_retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Directed self-checking bench for mem_wb_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_excp;
    logic [31:0] wb_retired;

    int n_checks;
    int n_pass;

    mem_wb_stage #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .CNT_W      (32),
        .BIG_ENDIAN (1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .mem_wreg    (mem_wreg),
        .mem_wd      (mem_wd),
        .mem_wdata   (mem_wdata),
        .mem_ld_type (mem_ld_type),
        .mem_addr_lo (mem_addr_lo),
        .mem_rdata   (mem_rdata),
        .wb_wreg     (wb_wreg),
        .wb_wd       (wb_wd),
        .wb_wdata    (wb_wdata),
        .wb_excp     (wb_excp),
        .wb_retired  (wb_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic [2:0] ld, input logic [1:0] alo, input logic [31:0] rdata);
        mem_wreg    = wreg;
        mem_wd      = wd;
        mem_wdata   = wdata;
        mem_ld_type = ld;
        mem_addr_lo = alo;
        mem_rdata   = rdata;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_triple(input string tag, input logic wreg, input logic [4:0] wd,
                                input logic [31:0] wdata, input logic [31:0] ret);
        check({tag, ".wreg"},    64'(wb_wreg),    64'(wreg));
        check({tag, ".wd"},      64'(wb_wd),      64'(wd));
        check({tag, ".wdata"},   64'(wb_wdata),   64'(wdata));
        check({tag, ".retired"}, 64'(wb_retired), 64'(ret));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush     = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0);
        #2;
        check_triple("reset", 1'b0, 5'd0, 32'h0, 32'd0);
        check("reset.excp", 64'(wb_excp), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        drive(1'b1, 5'd3, 32'h12345678, 3'd0, 2'd0, 32'hCAFEF00D);
        step;
        check_triple("alu", 1'b1, 5'd3, 32'h12345678, 32'd1);

        drive(1'b1, 5'd4, 32'h0, 3'd1, 2'd0, 32'h80FF7F01);
        step;
        check_triple("lb0", 1'b1, 5'd4, 32'hFFFFFF80, 32'd2);
        drive(1'b1, 5'd6, 32'h0, 3'd2, 2'd1, 32'h80FF7F01);
        step;
        check("lbu1.wdata", 64'(wb_wdata), 64'h000000FF);
        drive(1'b1, 5'd6, 32'h0, 3'd3, 2'd2, 32'h80FF7F01);
        step;
        check("lh2.wdata", 64'(wb_wdata), 64'h00007F01);
        drive(1'b1, 5'd6, 32'h0, 3'd4, 2'd0, 32'h80FF7F01);
        step;
        check("lhu0.wdata", 64'(wb_wdata), 64'h000080FF);
        drive(1'b1, 5'd6, 32'h0, 3'd1, 2'd3, 32'h80FF7F01);
        step;
        check("lb3.wdata", 64'(wb_wdata), 64'h00000001);
        drive(1'b1, 5'd6, 32'h0, 3'd3, 2'd0, 32'h80FF7F01);
        step;
        check_triple("lh0", 1'b1, 5'd6, 32'hFFFF80FF, 32'd7);
        drive(1'b1, 5'd6, 32'h0, 3'd5, 2'd0, 32'h80FF7F01);
        step;
        check_triple("lw0", 1'b1, 5'd6, 32'h80FF7F01, 32'd8);

        drive(1'b1, 5'd7, 32'hDEADBEEF, 3'd6, 2'd0, 32'h80FF7F01);
        step;
        check_triple("rsvd", 1'b0, 5'd7, 32'hDEADBEEF, 32'd8);

        drive(1'b1, 5'd5, 32'hA5A5A5A5, 3'd0, 2'd0, 32'h0);
        step;
        check_triple("stall.load", 1'b1, 5'd5, 32'hA5A5A5A5, 32'd9);
        stall_wb = 1'b1;
        drive(1'b1, 5'd9, 32'h11111111, 3'd0, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step;
            check_triple($sformatf("stall.hold%0d", i), 1'b0, 5'd5, 32'hA5A5A5A5, 32'd9);
        end
        stall_wb = 1'b0;

        stall_mem = 1'b1;
        drive(1'b1, 5'd8, 32'h22222222, 3'd0, 2'd0, 32'h0);
        step;
        check_triple("stallmem", 1'b0, 5'd0, 32'h0, 32'd9);
        stall_mem = 1'b0;

        drive(1'b1, 5'd10, 32'h33333333, 3'd0, 2'd0, 32'h0);
        step;
        check_triple("preflush", 1'b1, 5'd10, 32'h33333333, 32'd10);
        flush    = 1'b1;
        stall_wb = 1'b1;
        step;
        check_triple("flush", 1'b0, 5'd0, 32'h0, 32'd10);
        flush    = 1'b0;
        stall_wb = 1'b0;

        drive(1'b1, 5'd0, 32'h44444444, 3'd0, 2'd0, 32'h0);
        step;
        check_triple("r0", 1'b1, 5'd0, 32'h44444444, 32'd10);

        drive(1'b1, 5'd11, 32'h0, 3'd5, 2'd2, 32'h89ABCDEF);
        step;
`ifdef WB_MISALIGN_CHECK_EN
        check("mis.wreg",    64'(wb_wreg),    64'd0);
        check("mis.excp",    64'(wb_excp),    64'd1);
        check("mis.retired", 64'(wb_retired), 64'd10);
`else
        check_triple("mis", 1'b1, 5'd11, 32'h89ABCDEF, 32'd11);
        check("mis.excp", 64'(wb_excp), 64'd0);
`endif

        drive(1'b1, 5'd12, 32'h55555555, 3'd0, 2'd0, 32'h0);
        step;
        stall_wb = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_triple("async_rst", 1'b0, 5'd0, 32'h0, 32'd0);
        check("async_rst.excp", 64'(wb_excp), 64'd0);
        @(negedge clk);
        rst      = 1'b1;
        stall_wb = 1'b0;
        drive(1'b1, 5'd13, 32'h66666666, 3'd0, 2'd0, 32'h0);
        step;
        check_triple("post_rst", 1'b1, 5'd13, 32'h66666666, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the register file's write port.
- Aligns and sign/zero-extends load data, then registers the write-back triple (wb_wreg, wb_wd, wb_wdata).
- The register file consumes this triple on the next clock edge.
- Honours pipeline stall/flush controls and counts retired register writes for debug.

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- ADDR_W, 5, register address width.
- CNT_W, 32, width of the retired-write counter.
- BIG_ENDIAN, 1, 1: byte offset 0 is rdata[31:24]; 0: byte offset 0 is rdata[7:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  discard the in-flight instruction; has priority over stalls.
- mem_wreg  in  1  MEM instruction writes a register.
- mem_wd  in  ADDR_W  destination register.
- mem_wdata  in  DATA_W  ALU/move result.
- mem_ld_type  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6-7 reserved.
- mem_addr_lo  in  2  low bits of the load address.
- mem_rdata  in  DATA_W  raw data-memory read word.
- wb_wreg  out  1  regfile write enable.
- wb_wd  out  ADDR_W  regfile write address.
- wb_wdata  out  DATA_W  regfile write data.
- wb_excp  out  1  misaligned-load flag (macro-dependent).
- wb_retired  out  CNT_W  count of committed register writes.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, including wb_retired.
- Latency: MEM inputs sampled at edge N appear on the outputs after edge N. All outputs are registered; there is no combinational input-to-output path.
- Load alignment (combinational, before the register), byte index b = mem_addr_lo, big-endian mapping:
  - LB: sign-extend byte b.
  - LBU: zero-extend byte b.
  - LH: sign-extend halfword mem_addr_lo[1].
  - LHU: zero-extend halfword mem_addr_lo[1].
  - LW: full word.
  - type 0: mem_wdata.
  - type 6-7: treated as type 0 with the write enable forced to 0.
- Update priority at each rising edge:
  - flush=1: load a bubble (wb_wreg=0, wb_wd=0, wb_wdata=0, wb_excp=0).
  - else stall_mem=1 and stall_wb=0: load a bubble.
  - else stall_wb=1: hold all registered outputs, except wb_wreg, which is forced to 0 after the first held cycle. A held write commits exactly once.
  - else: load the aligned result.
- Writes to r0:
  - wb_wreg passes through as given.
  - wb_retired does not increment for wd=0.
- wb_retired: increments by 1 at each edge where a new entry is loaded with wb_wreg=1 and wb_wd!=0. Wraps modulo 2^CNT_W.
- Reset mid-stall or mid-flush: reset wins immediately; there is no residual held write.

Optional Feature:
- Macro: WB_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned load (LH/LHU with mem_addr_lo[0]=1, or LW with mem_addr_lo!=0) loads wb_wreg=0.
  - wb_excp=1 for that entry.
  - wb_retired is not incremented.
- Undefined:
  - wb_excp is tied to 0.
  - Misaligned loads ignore the offending low bits: LH uses addr_lo[1], LW uses the whole word.

Test Plan:
- Reset, then ALU write wreg=1, wd=3, wdata=0x12345678, type=0 -> next edge: wb_wreg=1, wb_wd=3, wb_wdata=0x12345678, wb_retired=1.
- LB, rdata=0x80FF7F01, addr_lo=0 -> wdata=0xFFFFFF80. LBU, addr_lo=1 -> 0x000000FF. LH, addr_lo=2 -> 0x00007F01. LHU, addr_lo=0 -> 0x000080FF.
- stall_wb held 3 cycles on an entry with wreg=1, wd=5 -> wb_wreg=1 for one cycle, then 0; wb_wd/wb_wdata held; wb_retired increments once.
- stall_mem=1, stall_wb=0 with a valid write -> bubble: wb_wreg=0. flush=1 together with stall_wb=1 -> bubble.
- Write with wd=0, wreg=1 -> wb_wreg=1, wb_retired unchanged. Then drop rst mid-operation -> all outputs 0 asynchronously.
- WB_MISALIGN_CHECK_EN defined, LW with addr_lo=2 -> wb_wreg=0, wb_excp=1. Undefined -> wb_wreg=1, wdata=rdata, wb_excp=0.
